// File: rtl/cuckoo_pkg.sv
// cuckoo_pkg: shared encodings, per-way salts and the index hash for the cuckoo hash engine
package cuckoo_pkg;

    typedef enum logic [1:0] {OP_LOOKUP, OP_INSERT, OP_DELETE, OP_RSVD} op_e;
    typedef enum logic [1:0] {ST_OK, ST_NOT_FOUND, ST_FULL, ST_BAD_OP} status_e;
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_KICK, S_RESP} state_e;

    localparam logic [31:0] SALT [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555};

    function automatic logic [31:0] hash_idx(input logic [31:0] key, input int way, input int table_size);
        return (key ^ SALT[way]) % 32'(table_size);
    endfunction

endpackage

// File: rtl/cuckoo_way_bank.sv
// cuckoo_way_bank: one hash way's key/value/valid storage
// Ports: clk, rst (sync, active-low, clears valid bits only);
//   rd_idx -> rd_valid/rd_key/rd_value combinational read;
//   wr_en/wr_idx/wr_key/wr_value write that also sets valid; clr_en/clr_idx clears valid.
module cuckoo_way_bank
    import cuckoo_pkg::*;
#(
    parameter int TABLE_SIZE  = 50,
    parameter int KEY_WIDTH   = 27,
    parameter int VALUE_WIDTH = 32,
    parameter int IDX_W       = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_valid,
    output logic [KEY_WIDTH-1:0]   rd_key,
    output logic [VALUE_WIDTH-1:0] rd_value,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [KEY_WIDTH-1:0]   wr_key,
    input  logic [VALUE_WIDTH-1:0] wr_value,
    input  logic                   clr_en,
    input  logic [IDX_W-1:0]       clr_idx
);

    logic [TABLE_SIZE-1:0]  valid_q, valid_d;
    logic [KEY_WIDTH-1:0]   key_q [TABLE_SIZE];
    logic [KEY_WIDTH-1:0]   key_d [TABLE_SIZE];
    logic [VALUE_WIDTH-1:0] val_q [TABLE_SIZE];
    logic [VALUE_WIDTH-1:0] val_d [TABLE_SIZE];

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        val_d   = val_q;
        if (clr_en) valid_d[clr_idx] = 1'b0;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            key_d[wr_idx]   = wr_key;
            val_d[wr_idx]   = wr_value;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= rst ? valid_d : '0;
        key_q   <= key_d;
        val_q   <= val_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_key   = key_q[rd_idx];
    assign rd_value = val_q[rd_idx];

endmodule

// File: rtl/cuckoo_hash_engine.sv
// cuckoo_hash_engine: N-way cuckoo exact-match key/value store with bounded-kick insert
// Ports: clk, rst (sync, active-low); req_valid/req_ready/req_op/req_key/req_value request;
//   rsp_valid pulse with rsp_status/rsp_value/rsp_key (held until next response);
//   occupancy = valid entries; collision = sticky FULL flag.
// Define CUCKOO_STASH_EN to add a one-entry stash that absorbs the pair dropped on FULL.
module cuckoo_hash_engine
    import cuckoo_pkg::*;
#(
    parameter int NUM_WAYS    = 3,
    parameter int TABLE_SIZE  = 50,
    parameter int KEY_WIDTH   = 27,
    parameter int VALUE_WIDTH = 32,
    parameter int MAX_KICKS   = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [1:0]                                  req_op,
    input  logic [KEY_WIDTH-1:0]                        req_key,
    input  logic [VALUE_WIDTH-1:0]                      req_value,
    output logic                                        rsp_valid,
    output logic [1:0]                                  rsp_status,
    output logic [VALUE_WIDTH-1:0]                      rsp_value,
    output logic [KEY_WIDTH-1:0]                        rsp_key,
    output logic [$clog2(NUM_WAYS*TABLE_SIZE+1)-1:0]    occupancy,
    output logic                                        collision
);

    localparam int IDX_W  = $clog2(TABLE_SIZE);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int KICK_W = $clog2(MAX_KICKS + 1);
    localparam int OCC_W  = $clog2(NUM_WAYS*TABLE_SIZE + 1);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d, carry_key_q, carry_key_d, rsp_key_q, rsp_key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d, carry_val_q, carry_val_d, rsp_value_q, rsp_value_d;
    logic [WAY_W-1:0]       kick_way_q, kick_way_d;
    logic [KICK_W-1:0]      kicks_q, kicks_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   coll_q, coll_d, rsp_valid_q, rsp_valid_d;
    status_e                rsp_status_q, rsp_status_d;

    logic [KEY_WIDTH-1:0]   probe_key;
    logic [IDX_W-1:0]       rd_idx [NUM_WAYS];
    logic                   bank_v [NUM_WAYS];
    logic [KEY_WIDTH-1:0]   bank_k [NUM_WAYS];
    logic [VALUE_WIDTH-1:0] bank_d [NUM_WAYS];
    logic [NUM_WAYS-1:0]    wr_en, clr_en;
    logic [KEY_WIDTH-1:0]   wr_key;
    logic [VALUE_WIDTH-1:0] wr_val;
    logic                   hit, free, stash_hit;
    logic [WAY_W-1:0]       hit_way, free_way;
    logic                   stash_v_q;
    logic [KEY_WIDTH-1:0]   stash_key_q;
    logic [VALUE_WIDTH-1:0] stash_val_q;

    // Every read and write in a cycle targets the slot hashed from probe_key,
    // so one index per way serves the read, write and clear ports.
    assign probe_key = (state_q == S_KICK) ? carry_key_q : key_q;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign rd_idx[w] = IDX_W'(hash_idx(32'(probe_key), w, TABLE_SIZE));
        cuckoo_way_bank #(
            .TABLE_SIZE(TABLE_SIZE), .KEY_WIDTH(KEY_WIDTH), .VALUE_WIDTH(VALUE_WIDTH), .IDX_W(IDX_W)
        ) u_bank (
            .clk(clk), .rst(rst),
            .rd_idx(rd_idx[w]), .rd_valid(bank_v[w]), .rd_key(bank_k[w]), .rd_value(bank_d[w]),
            .wr_en(wr_en[w]), .wr_idx(rd_idx[w]), .wr_key(wr_key), .wr_value(wr_val),
            .clr_en(clr_en[w]), .clr_idx(rd_idx[w])
        );
    end

    // Descending scan leaves the lowest-numbered match / free way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bank_v[i] && bank_k[i] == key_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!bank_v[i]) begin
                free     = 1'b1;
                free_way = WAY_W'(i);
            end
        end
    end

`ifdef CUCKOO_STASH_EN
    logic                   stash_v_d;
    logic [KEY_WIDTH-1:0]   stash_key_d;
    logic [VALUE_WIDTH-1:0] stash_val_d;
    always_ff @(posedge clk) begin
        stash_v_q   <= rst ? stash_v_d : 1'b0;
        stash_key_q <= stash_key_d;
        stash_val_q <= stash_val_d;
    end
`else
    assign stash_v_q   = 1'b0;
    assign stash_key_q = '0;
    assign stash_val_q = '0;
`endif

    assign stash_hit = stash_v_q && stash_key_q == key_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        value_d      = value_q;
        carry_key_d  = carry_key_q;
        carry_val_d  = carry_val_q;
        kick_way_d   = kick_way_q;
        kicks_d      = kicks_q;
        occ_d        = occ_q;
        coll_d       = coll_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = ST_OK;
        rsp_key_d    = key_q;
        rsp_value_d  = '0;
        wr_en        = '0;
        clr_en       = '0;
        wr_key       = key_q;
        wr_val       = value_q;
`ifdef CUCKOO_STASH_EN
        stash_v_d    = stash_v_q;
        stash_key_d  = stash_key_q;
        stash_val_d  = stash_val_q;
`endif
        case (state_q)
            S_IDLE: if (req_valid && req_ready) begin
                op_d    = op_e'(req_op);
                key_d   = req_key;
                value_d = req_value;
                state_d = S_PROBE;
            end
            S_PROBE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                case (op_q)
                    OP_LOOKUP: begin
                        if (hit) rsp_value_d = bank_d[hit_way];
                        else if (stash_hit) rsp_value_d = stash_val_q;
                        else rsp_status_d = ST_NOT_FOUND;
                    end
                    OP_DELETE: begin
                        if (hit) begin
                            clr_en[hit_way] = 1'b1;
                            occ_d           = occ_q - 1'b1;
                        end else if (stash_hit) begin
`ifdef CUCKOO_STASH_EN
                            stash_v_d = 1'b0;
`endif
                            occ_d = occ_q - 1'b1;
                        end else rsp_status_d = ST_NOT_FOUND;
                    end
                    OP_INSERT: begin
                        if (hit) wr_en[hit_way] = 1'b1;
                        else if (stash_hit) begin
`ifdef CUCKOO_STASH_EN
                            stash_val_d = value_q;
`endif
                        end else if (free) begin
                            wr_en[free_way] = 1'b1;
                            occ_d           = occ_q + 1'b1;
                        end else begin
                            // Table full at every candidate: new pair takes way 0, its resident starts kicking.
                            wr_en[0]    = 1'b1;
                            carry_key_d = bank_k[0];
                            carry_val_d = bank_d[0];
                            kick_way_d  = WAY_W'(1);
                            kicks_d     = KICK_W'(1);
                            state_d     = S_KICK;
                            rsp_valid_d = 1'b0;
                        end
                    end
                    default: rsp_status_d = ST_BAD_OP;
                endcase
            end
            S_KICK: begin
                wr_key = carry_key_q;
                wr_val = carry_val_q;
                if (!bank_v[kick_way_q]) begin
                    wr_en[kick_way_q] = 1'b1;
                    occ_d             = occ_q + 1'b1;
                    state_d           = S_RESP;
                    rsp_valid_d       = 1'b1;
                end else if (kicks_q == KICK_W'(MAX_KICKS)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
`ifdef CUCKOO_STASH_EN
                    if (!stash_v_q) begin
                        stash_v_d   = 1'b1;
                        stash_key_d = carry_key_q;
                        stash_val_d = carry_val_q;
                        occ_d       = occ_q + 1'b1;
                    end else
`endif
                    begin
                        // Table now holds the new key in the victim's place, so occupancy is unchanged.
                        rsp_status_d = ST_FULL;
                        rsp_key_d    = carry_key_q;
                        rsp_value_d  = carry_val_q;
                        coll_d       = 1'b1;
                    end
                end else begin
                    wr_en[kick_way_q] = 1'b1;
                    carry_key_d       = bank_k[kick_way_q];
                    carry_val_d       = bank_d[kick_way_q];
                    kick_way_d        = (kick_way_q == WAY_W'(NUM_WAYS - 1)) ? '0 : kick_way_q + 1'b1;
                    kicks_d           = kicks_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rsp_valid_d) begin
            rsp_status_d = rsp_status_q;
            rsp_key_d    = rsp_key_q;
            rsp_value_d  = rsp_value_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            value_q      <= '0;
            carry_key_q  <= '0;
            carry_val_q  <= '0;
            kick_way_q   <= '0;
            kicks_q      <= '0;
            occ_q        <= '0;
            coll_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_key_q    <= '0;
            rsp_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            value_q      <= value_d;
            carry_key_q  <= carry_key_d;
            carry_val_q  <= carry_val_d;
            kick_way_q   <= kick_way_d;
            kicks_q      <= kicks_d;
            occ_q        <= occ_d;
            coll_q       <= coll_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_key_q    <= rsp_key_d;
            rsp_value_q  <= rsp_value_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_value  = rsp_value_q;
    assign rsp_key    = rsp_key_q;
    assign occupancy  = occ_q;
    assign collision  = coll_q;

endmodule

// File: tb/tb_cuckoo_hash_engine.sv
// tb_cuckoo_hash_engine: scoreboard bench for a default table and a 2x2 table with 4 kicks
module tb_cuckoo_hash_engine;

    localparam logic [1:0] LOOKUP = 2'd0, INSERT = 2'd1, DELETE = 2'd2, RSVD = 2'd3;
    localparam logic [1:0] OK = 2'd0, NF = 2'd1, FULL = 2'd2, BAD = 2'd3;

    typedef struct {
        logic [1:0]  st;
        logic [26:0] key;
        logic [31:0] val;
        bit          chkv;
        int          due;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        b_valid, b_ready, b_rv, b_coll, s_valid, s_ready, s_rv, s_coll;
    logic [1:0]  b_op, b_rs, s_op, s_rs;
    logic [26:0] b_key, b_rkey, s_key, s_rkey;
    logic [31:0] b_val, b_rval, s_val, s_rval;
    logic [7:0]  b_occ;
    logic [2:0]  s_occ;

    cuckoo_hash_engine u_big (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_key(b_key), .req_value(b_val), .rsp_valid(b_rv), .rsp_status(b_rs),
        .rsp_value(b_rval), .rsp_key(b_rkey), .occupancy(b_occ), .collision(b_coll)
    );

    cuckoo_hash_engine #(.NUM_WAYS(2), .TABLE_SIZE(2), .MAX_KICKS(4)) u_small (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready), .req_op(s_op),
        .req_key(s_key), .req_value(s_val), .rsp_valid(s_rv), .rsp_status(s_rs),
        .rsp_value(s_rval), .rsp_key(s_rkey), .occupancy(s_occ), .collision(s_coll)
    );

    exp_t qb[$], qs[$];
    int vecs = 0, errs = 0;

    task automatic cmp(input string nm, input exp_t e, input logic [1:0] st, input logic [26:0] k, input logic [31:0] v);
        vecs++;
        if (st !== e.st || k !== e.key || (e.chkv && v !== e.val) || cyc != e.due) begin
            errs++;
            $display("FAIL %s rsp: got st=%0d key=%0h val=%0h cyc=%0d, expected st=%0d key=%0h val=%0h cyc=%0d",
                     nm, st, k, v, cyc, e.st, e.key, e.val, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (b_rv) begin
            if (qb.size() == 0) begin
                vecs++; errs++;
                $display("FAIL big unexpected rsp: got st=%0d key=%0h, expected no response", b_rs, b_rkey);
            end else cmp("big", qb.pop_front(), b_rs, b_rkey, b_rval);
        end
        if (s_rv) begin
            if (qs.size() == 0) begin
                vecs++; errs++;
                $display("FAIL small unexpected rsp: got st=%0d key=%0h, expected no response", s_rs, s_rkey);
            end else cmp("small", qs.pop_front(), s_rs, s_rkey, s_rval);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [1:0] op, input logic [26:0] k, input logic [31:0] v,
                        input logic [1:0] est, input logic [26:0] ekey, input logic [31:0] eval,
                        input bit chkv, input int lat, input bit expect_rsp);
        int n;
        exp_t e;
        @(negedge clk);
        if (d == 0) begin b_valid = 1'b1; b_op = op; b_key = k; b_val = v; end
        else begin s_valid = 1'b1; s_op = op; s_key = k; s_val = v; end
        n = 0;
        while (!((d == 0) ? b_ready : s_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            vecs++; errs++;
            $display("FAIL accept dut%0d: req_ready stayed 0, required 1", d);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        s_valid = 1'b0;
        e = '{st: est, key: ekey, val: eval, chkv: chkv, due: cyc + lat - 1};
        if (expect_rsp) begin
            if (d == 0) qb.push_back(e);
            else qs.push_back(e);
            n = 0;
            while (((d == 0) ? qb.size() : qs.size()) != 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n == 60) begin
                vecs++; errs++;
                $display("FAIL timeout dut%0d: no response, required one", d);
                if (d == 0) qb.delete(); else qs.delete();
            end
        end
    endtask

    task automatic look(input int d, input logic [26:0] k, input logic [1:0] est, input logic [31:0] eval);
        send(d, LOOKUP, k, 32'h0, est, k, eval, 1'b1, 2, 1'b1);
    endtask

    task automatic ins(input int d, input logic [26:0] k, input logic [31:0] v);
        send(d, INSERT, k, v, OK, k, 32'h0, 1'b0, 2, 1'b1);
    endtask

    task automatic del(input int d, input logic [26:0] k, input logic [1:0] est);
        send(d, DELETE, k, 32'h0, est, k, 32'h0, 1'b0, 2, 1'b1);
    endtask

    initial begin
        b_valid = 1'b0; b_op = '0; b_key = '0; b_val = '0;
        s_valid = 1'b0; s_op = '0; s_key = '0; s_val = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", b_ready, 1);
        chk("occ_reset", b_occ, 0);
        chk("coll_reset", b_coll, 0);
        look(0, 0, NF, 0);
        ins(0, 0, 32'hDEAD);
        look(0, 0, OK, 32'hDEAD);
        chk("occ_key0", b_occ, 1);
        del(0, 0, OK);
        ins(0, 7, 1);
        ins(0, 7, 2);
        look(0, 7, OK, 2);
        chk("occ_update", b_occ, 1);
        del(0, 7, OK);
        look(0, 7, NF, 0);
        chk("occ_delete", b_occ, 0);
        del(0, 7, NF);
        ins(0, 7, 1);
        ins(0, 57, 2);
        ins(0, 107, 3);
        look(0, 7, OK, 1);
        look(0, 57, OK, 2);
        look(0, 107, OK, 3);
        chk("occ_same_idx", b_occ, 3);
        send(0, RSVD, 57, 32'h99, BAD, 57, 32'h0, 1'b0, 2, 1'b1);
        look(0, 57, OK, 2);
        chk("occ_bad_op", b_occ, 3);
        look(0, 8, NF, 0);

        for (int k = 1; k <= 4; k++) ins(1, 27'(k), 32'h100 + 32'(k));
        chk("small_occ_4", s_occ, 4);
        chk("small_coll_0", s_coll, 0);
`ifdef CUCKOO_STASH_EN
        send(1, INSERT, 5, 32'h105, OK, 5, 32'h0, 1'b0, 6, 1'b1);
        chk("small_occ_stash", s_occ, 5);
        chk("small_coll_stash", s_coll, 0);
        look(1, 1, OK, 32'h101);
`else
        send(1, INSERT, 5, 32'h105, FULL, 1, 32'h101, 1'b1, 6, 1'b1);
        chk("small_occ_full", s_occ, 4);
        chk("small_coll_full", s_coll, 1);
        look(1, 1, NF, 0);
`endif
        look(1, 5, OK, 32'h105);
        look(1, 3, OK, 32'h103);
        send(1, INSERT, 6, 32'h106, FULL, 2, 32'h102, 1'b1, 6, 1'b1);
        chk("small_coll_6", s_coll, 1);
`ifdef CUCKOO_STASH_EN
        chk("small_occ_6", s_occ, 5);
`else
        chk("small_occ_6", s_occ, 4);
`endif
        look(1, 2, NF, 0);
        look(1, 6, OK, 32'h106);
        ins(1, 4, 32'h444);
        look(1, 4, OK, 32'h444);

        send(1, INSERT, 7, 32'h107, OK, 7, 32'h0, 1'b0, 6, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", s_ready, 1);
        chk("small_occ_abort", s_occ, 0);
        chk("small_coll_abort", s_coll, 0);
        chk("big_occ_abort", b_occ, 0);
        repeat (8) @(negedge clk);
        look(1, 1, NF, 0);
        look(1, 5, NF, 0);
        look(1, 6, NF, 0);
        look(1, 7, NF, 0);
        look(0, 57, NF, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
